// File: rtl/lift_vq_subtract_if.sv
// Stream bundle for the final Shoup-lift subtract stage: x_i/p_i input,
// v*q input and the reduced residue output.
interface lift_vq_subtract_if #(
   parameter int W = 30
);
   logic [W-1:0] sop_in;
   logic [W-1:0] sop_mod;
   logic         sop_valid;
   logic [W-1:0] vq_in;
   logic         vq_valid;
   logic [W-1:0] result;
   logic         result_valid;
   logic         result_last;

   modport master (
      output sop_in, sop_mod, sop_valid, vq_in, vq_valid,
      input  result, result_valid, result_last
   );

   modport slave (
      input  sop_in, sop_mod, sop_valid, vq_in, vq_valid,
      output result, result_valid, result_last
   );
endinterface

// File: rtl/lift_vq_subtract.sv
// Shoup lift final stage: buffers {x_i, p_i}, pairs each entry with the next
// v*q word and emits (x_i - vq_i) mod p_i. Option macro: LIFT_SUB_RANGE_CHECK_EN.
module lift_vq_subtract #(
   parameter int DEPTH = 8,
   parameter int WORDS = 7,
   parameter int W     = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   lift_vq_subtract_if.slave bus,
   output logic              busy,
   output logic              fifo_ovf,
   output logic              fifo_unf,
   output logic              range_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

   logic [2*W-1:0] fifo_mem [DEPTH];
   logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW-1:0]  waddr;
   logic           full, empty, push_ok, pop_ok;
   logic [W-1:0]   head_x, head_p;

   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_q, busy_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;

   logic           s1_valid_q, s1_valid_d;
   logic [W:0]     s1_diff_q, s1_diff_d;
   logic [W-1:0]   s1_p_q, s1_p_d;
   logic [CW-1:0]  s1_idx_q, s1_idx_d;

   logic [W-1:0]   result_q, result_d;
   logic           result_valid_q, result_valid_d;
   logic           result_last_q, result_last_d;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign {head_p, head_x} = fifo_mem[rptr_q[AW-1:0]];

   always_comb begin
      // A start cycle flushes the FIFO, so its pop is dropped and its push lands at slot 0.
      pop_ok  = bus.vq_valid && !empty && !start;
      push_ok = bus.sop_valid && (start || !full || pop_ok);
      waddr   = start ? '0 : wptr_q[AW-1:0];

      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;

      if (start) begin
         rptr_d = '0;
         wptr_d = push_ok ? (AW+1)'(1) : '0;
         cnt_d  = '0;
         busy_d = 1'b1;
         ovf_d  = 1'b0;
         unf_d  = 1'b0;
      end else begin
         if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
         if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
         if (bus.sop_valid && !push_ok) ovf_d = 1'b1;
         if (bus.vq_valid && empty)     unf_d = 1'b1;
         if (pop_ok) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
         if (s1_valid_q && (s1_idx_q == LAST_IDX)) busy_d = 1'b0;
      end

      s1_valid_d = pop_ok;
      s1_diff_d  = s1_diff_q;
      s1_p_d     = s1_p_q;
      s1_idx_d   = s1_idx_q;
      if (pop_ok) begin
         s1_diff_d = {1'b0, head_x} - {1'b0, bus.vq_in};
         s1_p_d    = head_p;
         s1_idx_d  = cnt_q;
      end

      // Borrow out of the W+1-bit difference means x < vq: fold back by adding p.
      result_valid_d = s1_valid_q;
      result_last_d  = s1_valid_q && (s1_idx_q == LAST_IDX);
      result_d       = result_q;
      if (s1_valid_q) begin
         result_d = s1_diff_q[W] ? (s1_diff_q[W-1:0] + s1_p_q) : s1_diff_q[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[waddr] <= {bus.sop_mod, bus.sop_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q         <= '0;
         rptr_q         <= '0;
         cnt_q          <= '0;
         busy_q         <= 1'b0;
         ovf_q          <= 1'b0;
         unf_q          <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_diff_q      <= '0;
         s1_p_q         <= '0;
         s1_idx_q       <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         result_last_q  <= 1'b0;
      end else begin
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         cnt_q          <= cnt_d;
         busy_q         <= busy_d;
         ovf_q          <= ovf_d;
         unf_q          <= unf_d;
         s1_valid_q     <= s1_valid_d;
         s1_diff_q      <= s1_diff_d;
         s1_p_q         <= s1_p_d;
         s1_idx_q       <= s1_idx_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         result_last_q  <= result_last_d;
      end
   end

`ifdef LIFT_SUB_RANGE_CHECK_EN
   logic range_err_q, range_err_d;

   always_comb begin
      range_err_d = range_err_q;
      if (start) begin
         range_err_d = 1'b0;
      end else if (pop_ok && ((head_x >= head_p) || (bus.vq_in >= head_p))) begin
         range_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) range_err_q <= 1'b0;
      else     range_err_q <= range_err_d;
   end

   assign range_err = range_err_q;
`else
   assign range_err = 1'b0;
`endif

   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.result_last  = result_last_q;
   assign busy             = busy_q;
   assign fifo_ovf         = ovf_q;
   assign fifo_unf         = unf_q;

endmodule

// File: doc/lift_vq_subtract.md
Name: lift_vq_subtract

Overview:
- Final stage of the Shoup lift datapath. Sits directly downstream of the v*q mod p_i stage.
- Computes (x_i - v*q mod p_i) mod p_i per prime channel: x_i is the partial sum-of-products residue, the second operand is the stream from the upstream stage.
- The x_i stream arrives earlier than the v*q stream. The block buffers x_i and its modulus in a small FIFO, then pairs each entry with the next v*q word.
- Emits one reduced 30-bit residue per channel, with a last-word marker.

Parameters:
- DEPTH, 8, FIFO entries of {x_i, p_i}; power of two, minimum 2.
- WORDS, 7, channel words per transfer (rd_addr 0..6 upstream).
- W, 30, residue and modulus width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a transfer, clears word counter and FIFO
- sop_in  in  W  x_i residue, must be < p_i
- sop_mod  in  W  modulus p_i belonging to sop_in
- sop_valid  in  1  push {sop_in, sop_mod} into FIFO
- vq_in  in  W  v*q mod p_i word from upstream stage
- vq_valid  in  1  vq_in valid; pops the FIFO head
- result  out  W  (x_i - vq_i) mod p_i
- result_valid  out  1  result qualifier
- result_last  out  1  high with result_valid on word WORDS-1
- busy  out  1  transfer in progress
- fifo_ovf  out  1  sticky: push while full
- fifo_unf  out  1  sticky: vq_valid while empty
- range_err  out  1  sticky range flag (optional feature)

Behaviour:
- Reset values: all outputs 0, FIFO empty, word counter 0, pipeline valids 0.
- Reset is asynchronous; asserting it mid-transfer aborts the transfer immediately, with no partial result_valid afterwards.
- FIFO:
  - Pointers of width log2(DEPTH)+1; full and empty are decoded from the pointer MSB difference.
  - Push when sop_valid and not full. Pop when vq_valid and not empty.
  - Push and pop in the same cycle while full: both happen, count unchanged.
  - Push and pop in the same cycle while empty: the pop is an underflow; the push still happens.
- Errors:
  - sop_valid while full and no simultaneous pop: word dropped, fifo_ovf set.
  - vq_valid while empty: word dropped, fifo_unf set, no result.
  - Both flags are cleared only by rst or start.
- start:
  - Flushes the FIFO, zeroes the word counter and clears the sticky flags. busy goes to 1 the next cycle.
  - Pipeline words already in flight still emerge and keep their result_last.
  - A push (sop_valid) in the start cycle is accepted after the flush.
- Pipeline, 2 cycles from the vq_valid pop to result_valid:
  - S1 registers d = {1'b0, x} - {1'b0, vq} (W+1 bits), plus p, word index and last.
  - S2 registers result = d[W] ? d[W-1:0] + p : d[W-1:0], truncated to W bits.
  - For x < p and vq < p, result lies in [0, p).
- Word counter:
  - Increments on each accepted pop. result_last is tagged when counter == WORDS-1.
  - After the last pop the counter wraps to 0.
  - busy drops in the cycle the last-tagged word reaches S2 output.
  - Pops outside busy are still processed; they are counted from 0 and do not assert busy.
- result holds its last value when result_valid is 0.

Optional Feature:
- Macro LIFT_SUB_RANGE_CHECK_EN.
- Defined: at S1, if x >= p or vq >= p, range_err is set (sticky, cleared by rst or start). The result is still computed by the same formula.
- Undefined: range_err is tied to 0 and no comparators are built.

Test Plan:
- Reset mid-transfer: rst during word 3 -> result_valid, busy and flags 0 at once; FIFO empty after release.
- Basic transfer: start, push 7 words x=100, p=1000003, then 7 vq=40 -> seven results of 60 at vq+2 cycles; result_last on the 7th only; busy then 0.
- Wrap path: x=5, vq=20, p=1000003 -> 999988. Also x=0, vq=0 -> 0. Also x=1000002, vq=0 -> 1000002.
- Full boundary:
  - 8 pushes fill the FIFO; a 9th push with no pop sets fifo_ovf and the word is discarded.
  - A 9th push in the same cycle as a pop is accepted, with no flag.
- Underflow: vq_valid with the FIFO empty -> fifo_unf=1, no result_valid; the next start clears it.
- Range (macro on): x=1000003, p=1000003 -> range_err=1. With the macro off, range_err stays 0.
